// File: rtl/usb_rx_bit_sampler.sv
// Recovers NRZI bits mid-bit from the synchronised bus, strips stuffed bits, flags stuff errors and EOP.
// Latency: pulses appear one clock after the sample cycle; no backpressure, one decision per bit time.
module usb_rx_bit_sampler #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POS   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d_plus_sync,
  input  logic d_minus_sync,
  input  logic edge_pulse,
  output logic bit_valid,
  output logic bit_out,
  output logic stuff_err,
  output logic eop,
  output logic eop_err,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, RUN, EOP_WAIT} state_t;

  localparam logic [3:0] PHASE_LAST = 4'(CLKS_PER_BIT - 1);
  localparam logic [3:0] PHASE_SAMP = 4'(SAMPLE_POS);

  state_t     state, state_n;
  logic [3:0] phase, phase_n;
  logic       prev_level, prev_level_n;
  logic [2:0] ones, ones_n;
  logic       bit_valid_n, bit_out_n, stuff_err_n, eop_n, eop_err_n;

  logic sample, se0, line_j, dec;
  logic [3:0] phase_adv;

  assign sample    = (state != IDLE) && (phase == PHASE_SAMP);
  assign se0       = !d_plus_sync && !d_minus_sync;
  assign line_j    = d_plus_sync && !d_minus_sync;
  assign dec       = (d_plus_sync == prev_level);
  // Any d_plus transition realigns the bit clock to the start of a symbol.
  assign phase_adv = edge_pulse ? 4'd1 : ((phase == PHASE_LAST) ? 4'd0 : phase + 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 4'd0;
      prev_level <= 1'b1;
      ones       <= 3'd0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
      stuff_err  <= 1'b0;
      eop        <= 1'b0;
      eop_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      prev_level <= prev_level_n;
      ones       <= ones_n;
      bit_valid  <= bit_valid_n;
      bit_out    <= bit_out_n;
      stuff_err  <= stuff_err_n;
      eop        <= eop_n;
      eop_err    <= eop_err_n;
      busy       <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    prev_level_n = prev_level;
    ones_n       = ones;
    bit_valid_n  = 1'b0;
    bit_out_n    = bit_out;
    stuff_err_n  = 1'b0;
    eop_n        = 1'b0;
    eop_err_n    = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      ones_n  = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (edge_pulse) begin
            state_n      = RUN;
            prev_level_n = 1'b1;
            ones_n       = 3'd0;
          end
        end
        RUN: begin
          phase_n = phase_adv;
          if (sample) begin
            if (se0) begin
              state_n = EOP_WAIT;
            end else begin
              prev_level_n = d_plus_sync;
              if (ones == 3'd6) begin
                // After six ones the next bit must be a stuffed zero.
                if (dec) begin
                  stuff_err_n = 1'b1;
                  state_n     = IDLE;
                end else begin
                  ones_n = 3'd0;
                end
              end else begin
                bit_valid_n = 1'b1;
                bit_out_n   = dec;
                ones_n      = dec ? ones + 3'd1 : 3'd0;
              end
            end
          end
        end
        EOP_WAIT: begin
          phase_n = phase_adv;
          if (sample && !se0) begin
            eop_n     = line_j;
            eop_err_n = !line_j;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (state_n == IDLE) begin
      phase_n = 4'd0;
    end else if (state == IDLE) begin
      phase_n = 4'd1;
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_sampler.sv
// Randomised bench for usb_rx_bit_sampler against a symbol-level reference model.
module tb_usb_rx_bit_sampler;

  logic clk = 1'b0;
  logic rst, enable, d_plus_sync, d_minus_sync, edge_pulse;
  logic bit_valid, bit_out, stuff_err, eop, eop_err, busy;

  usb_rx_bit_sampler #(.CLKS_PER_BIT(8), .SAMPLE_POS(3)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .d_plus_sync(d_plus_sync), .d_minus_sync(d_minus_sync), .edge_pulse(edge_pulse),
    .bit_valid(bit_valid), .bit_out(bit_out), .stuff_err(stuff_err),
    .eop(eop), .eop_err(eop_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int multi = 0;

  // Observed events: 0/1 = decoded bit, 2 = stuff_err, 3 = eop, 4 = eop_err
  int got_kind[$];
  int got_cyc[$];
  bit got_busy[$];

  always @(negedge clk) begin
    int n;
    n = int'(bit_valid) + int'(stuff_err) + int'(eop) + int'(eop_err);
    if (n > 1) multi++;
    if (n > 0 && !rst) begin
      got_kind.push_back(bit_valid ? int'(bit_out) : stuff_err ? 2 : eop ? 3 : 4);
      got_cyc.push_back(cyc);
      got_busy.push_back(busy);
    end
  end

  byte sym_q[$];
  int  exp_kind[$];
  int  exp_idx[$];
  int  stop_idx;
  logic cur_dp = 1'b1;
  logic cur_dm = 1'b0;

  // Per-bit-time model: each symbol is sampled once; J/K/0 = J, K, SE0.
  task automatic build_model();
    bit prev = 1'b1;
    int ones = 0;
    bit in_eop = 1'b0;
    bit dp, dec;
    exp_kind.delete();
    exp_idx.delete();
    stop_idx = sym_q.size() - 1;
    for (int i = 0; i < sym_q.size(); i++) begin
      dp = (sym_q[i] == "J");
      if (in_eop) begin
        if (sym_q[i] == "0") continue;
        exp_kind.push_back(sym_q[i] == "J" ? 3 : 4);
        exp_idx.push_back(i);
        stop_idx = i;
        break;
      end
      if (sym_q[i] == "0") begin
        in_eop = 1'b1;
        continue;
      end
      dec  = (dp == prev);
      prev = dp;
      if (ones == 6) begin
        if (!dec) begin
          ones = 0;
          continue;
        end
        exp_kind.push_back(2);
        exp_idx.push_back(i);
        stop_idx = i;
        break;
      end
      exp_kind.push_back(int'(dec));
      exp_idx.push_back(i);
      ones = dec ? ones + 1 : 0;
    end
  endtask

  task automatic drive_cycle(input logic dp, input logic dm);
    edge_pulse   = (dp != cur_dp);
    d_plus_sync  = dp;
    d_minus_sync = dm;
    cur_dp       = dp;
    cur_dm       = dm;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input byte s, input int len);
    for (int c = 0; c < len; c++) drive_cycle(s == "J", s == "K");
  endtask

  task automatic hold(input int n);
    for (int c = 0; c < n; c++) drive_cycle(cur_dp, cur_dm);
  endtask

  task automatic idle_line();
    enable = 1'b0;
    for (int c = 0; c < 4; c++) drive_cycle(1'b1, 1'b0);
    enable = 1'b1;
    drive_cycle(1'b1, 1'b0);
  endtask

  task automatic clear_all();
    got_kind.delete();
    got_cyc.delete();
    got_busy.delete();
    sym_q.delete();
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) sym_q.push_back(s[i]);
  endtask

  // mode 0: 8-clock symbols; mode 1: alternating 7/9-clock symbols
  task automatic send_packet(input int mode, output int t0);
    t0 = cyc;
    for (int i = 0; i <= stop_idx; i++)
      send_sym(sym_q[i], mode == 0 ? 8 : ((i % 2 == 0) ? 7 : 9));
  endtask

  task automatic test_reset();
    int t0;
    tests++;
    if ({bit_valid, bit_out, stuff_err, eop, eop_err, busy} !== 6'b0) begin
      fails++;
      $display("FAIL reset_state: outputs=%b want 000000", {bit_valid, bit_out, stuff_err, eop, eop_err, busy});
    end
    rst = 1'b0;
    idle_line();
    clear_all();
    push_str("KJKJKJKK");
    for (int i = 0; i < 4; i++) send_sym(sym_q[i], 8);
    for (int c = 0; c < 3; c++) drive_cycle(1'b1, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b1, 1'b0);
      tests++;
      if ({bit_valid, bit_out, stuff_err, eop, eop_err, busy} !== 6'b0) begin
        fails++;
        $display("FAIL reset_midpacket cycle %0d: outputs=%b want 000000", c,
                 {bit_valid, bit_out, stuff_err, eop, eop_err, busy});
      end
    end
    rst = 1'b0;
    idle_line();
    clear_all();
    push_str("KJKJKJKK00J");
    build_model();
    send_packet(0, t0);
    hold(12);
    tests++;
    if (got_kind.size() !== exp_kind.size()) begin
      fails++;
      $display("FAIL reset_resync count: got %0d want %0d", got_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < got_kind.size(); i++) begin
      tests++;
      if (got_kind[i] !== exp_kind[i]) begin
        fails++;
        $display("FAIL reset_resync ev%0d: kind %0d want %0d", i, got_kind[i], exp_kind[i]);
      end
    end
    idle_line();
  endtask

  task automatic test_sync();
    int t0;
    clear_all();
    push_str("KJKJKJKK00J");
    build_model();
    send_packet(0, t0);
    hold(12);
    tests++;
    if (got_kind.size() !== exp_kind.size()) begin
      fails++;
      $display("FAIL sync count: got %0d want %0d", got_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < got_kind.size(); i++) begin
      tests++;
      if (got_kind[i] !== exp_kind[i] || got_cyc[i] !== t0 + 4 + 8 * exp_idx[i]) begin
        fails++;
        $display("FAIL sync ev%0d: kind %0d @%0d want %0d @%0d", i, got_kind[i], got_cyc[i],
                 exp_kind[i], t0 + 4 + 8 * exp_idx[i]);
      end
    end
    idle_line();
  endtask

  task automatic test_stuffing();
    int t0;
    string pats[2];
    pats[0] = "KJKJKJKKKKKKKJKK00J";
    pats[1] = "KJKJKJKKKKKKKK";
    for (int p = 0; p < 2; p++) begin
      clear_all();
      push_str(pats[p]);
      build_model();
      send_packet(0, t0);
      hold(12);
      tests++;
      if (got_kind.size() !== exp_kind.size()) begin
        fails++;
        $display("FAIL stuff%0d count: got %0d want %0d", p, got_kind.size(), exp_kind.size());
      end
      for (int i = 0; i < exp_kind.size() && i < got_kind.size(); i++) begin
        tests++;
        if (got_kind[i] !== exp_kind[i] || got_cyc[i] !== t0 + 4 + 8 * exp_idx[i] ||
            got_busy[i] !== (exp_kind[i] < 2)) begin
          fails++;
          $display("FAIL stuff%0d ev%0d: kind %0d @%0d busy %0b want %0d @%0d busy %0b", p, i,
                   got_kind[i], got_cyc[i], got_busy[i], exp_kind[i],
                   t0 + 4 + 8 * exp_idx[i], exp_kind[i] < 2);
        end
      end
      idle_line();
    end
  endtask

  task automatic test_eop();
    int t0;
    string pats[2];
    pats[0] = "KJKJKJKKJK00J";
    pats[1] = "KJKJKJKKK00K";
    for (int p = 0; p < 2; p++) begin
      clear_all();
      push_str(pats[p]);
      build_model();
      send_packet(0, t0);
      hold(12);
      tests++;
      if (got_kind.size() !== exp_kind.size()) begin
        fails++;
        $display("FAIL eop%0d count: got %0d want %0d", p, got_kind.size(), exp_kind.size());
      end
      for (int i = 0; i < exp_kind.size() && i < got_kind.size(); i++) begin
        tests++;
        if (got_kind[i] !== exp_kind[i] || got_cyc[i] !== t0 + 4 + 8 * exp_idx[i] ||
            got_busy[i] !== (exp_kind[i] < 2)) begin
          fails++;
          $display("FAIL eop%0d ev%0d: kind %0d @%0d busy %0b want %0d @%0d busy %0b", p, i,
                   got_kind[i], got_cyc[i], got_busy[i], exp_kind[i],
                   t0 + 4 + 8 * exp_idx[i], exp_kind[i] < 2);
        end
      end
      idle_line();
    end
  endtask

  task automatic test_random();
    int t0;
    byte lvl;
    for (int p = 0; p < 4; p++) begin
      clear_all();
      push_str("KJKJKJKK");
      lvl = "K";
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(3, 0) == 0) lvl = (lvl == "K") ? "J" : "K";
        sym_q.push_back(lvl);
      end
      push_str("00J");
      build_model();
      send_packet(0, t0);
      hold(12);
      tests++;
      if (got_kind.size() !== exp_kind.size()) begin
        fails++;
        $display("FAIL random%0d count: got %0d want %0d", p, got_kind.size(), exp_kind.size());
      end
      for (int i = 0; i < exp_kind.size() && i < got_kind.size(); i++) begin
        tests++;
        if (got_kind[i] !== exp_kind[i] || got_cyc[i] !== t0 + 4 + 8 * exp_idx[i]) begin
          fails++;
          $display("FAIL random%0d ev%0d: kind %0d @%0d want %0d @%0d", p, i, got_kind[i],
                   got_cyc[i], exp_kind[i], t0 + 4 + 8 * exp_idx[i]);
        end
      end
      idle_line();
    end
  endtask

  task automatic test_jitter_enable();
    int t0, k, run;
    byte lvl;
    byte all_q[$];
    for (int p = 0; p < 3; p++) begin
      clear_all();
      push_str("KJKJKJKK");
      lvl = "K";
      run = 1;
      for (int i = 0; i < 24; i++) begin
        // At most three symbols at one level keeps 7/9-clock drift inside the bit.
        if (run >= 2 || $urandom_range(1, 0) == 0) begin
          lvl = (lvl == "K") ? "J" : "K";
          run = 0;
        end else begin
          run++;
        end
        sym_q.push_back(lvl);
      end
      all_q = sym_q;
      k = $urandom_range(20, 14);
      while (sym_q.size() > k) void'(sym_q.pop_back());
      build_model();
      send_packet(1, t0);
      enable = 1'b0;
      drive_cycle(all_q[k] == "J", all_q[k] == "K");
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL jitter%0d busy after disable: got %0b want 0", p, busy);
      end
      send_sym(all_q[k], ((k % 2 == 0) ? 7 : 9) - 1);
      for (int i = k + 1; i < all_q.size(); i++)
        send_sym(all_q[i], (i % 2 == 0) ? 7 : 9);
      hold(8);
      tests++;
      if (got_kind.size() !== exp_kind.size()) begin
        fails++;
        $display("FAIL jitter%0d count: got %0d want %0d", p, got_kind.size(), exp_kind.size());
      end
      for (int i = 0; i < exp_kind.size() && i < got_kind.size(); i++) begin
        tests++;
        if (got_kind[i] !== exp_kind[i]) begin
          fails++;
          $display("FAIL jitter%0d ev%0d: kind %0d want %0d", p, i, got_kind[i], exp_kind[i]);
        end
      end
      idle_line();
    end
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    d_plus_sync  = 1'b1;
    d_minus_sync = 1'b0;
    edge_pulse   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_sync();
    test_stuffing();
    test_eop();
    test_random();
    test_jitter_enable();
    tests++;
    if (multi !== 0) begin
      fails++;
      $display("FAIL exclusive_pulses: %0d cycles with overlapping pulses, want 0", multi);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
